// File: rtl/nearest_centroid.sv
// rtl/nearest_centroid.sv - k-means assignment stage: scans K centroids and returns the nearest index/distance.
// Distances compare as unsigned magnitudes with the sign bit masked, so -0.0 ties +0.0 and NaN/inf sort last.
`timescale 1ns/1ps
module nearest_centroid #(
  parameter int MAX_K = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [63:0]      io_px,
  input  logic [63:0]      io_py,
  input  logic [IDX_W:0]   io_num_centroids,
  output logic             io_cent_en,
  output logic [IDX_W-1:0] io_cent_addr,
  input  logic [63:0]      io_cent_x,
  input  logic [63:0]      io_cent_y,
  output logic [63:0]      io_dist_p1x,
  output logic [63:0]      io_dist_p1y,
  output logic [63:0]      io_dist_p2x,
  output logic [63:0]      io_dist_p2y,
  input  logic [63:0]      io_dist,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [IDX_W-1:0] io_out_idx,
  output logic [63:0]      io_out_dist
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [63:0]        px_q, py_q;
  logic [IDX_W-1:0]   k_last, k_last_in;
  logic [IDX_W-1:0]   rd_idx;
  logic               cmp_valid;
  logic [IDX_W-1:0]   cmp_idx;
  logic               have_best;
  logic [IDX_W-1:0]   best_idx;
  logic [63:0]        best_dist;
  logic [IDX_W:0]     k_sat;
  logic               accept;
  logic               take_new;

  always_comb begin
    k_sat = io_num_centroids;
    if (io_num_centroids == '0)
      k_sat = (IDX_W+1)'(1);
    else if (io_num_centroids > (IDX_W+1)'(MAX_K))
      k_sat = (IDX_W+1)'(MAX_K);
  end

  assign k_last_in = IDX_W'(k_sat - (IDX_W+1)'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    io_in_ready  = 1'b0;
    io_cent_en   = 1'b0;
    io_cent_addr = '0;
    io_out_valid = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        io_cent_en   = 1'b1;
        io_cent_addr = rd_idx;
        if (rd_idx == k_last) state_next = DRAIN;
      end
      DRAIN: state_next = DONE;
      DONE: begin
        io_out_valid = 1'b1;
        if (io_out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign bit is excluded from the magnitude compare; the first sample always loads.
  assign take_new = cmp_valid && (!have_best || (io_dist[62:0] < best_dist[62:0]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_q      <= '0;
      py_q      <= '0;
      k_last    <= '0;
      rd_idx    <= '0;
      cmp_valid <= 1'b0;
      cmp_idx   <= '0;
      have_best <= 1'b0;
      best_idx  <= '0;
      best_dist <= '0;
    end else begin
      cmp_valid <= (state == SCAN);
      cmp_idx   <= rd_idx;
      if (accept) begin
        px_q      <= io_px;
        py_q      <= io_py;
        k_last    <= k_last_in;
        rd_idx    <= '0;
        have_best <= 1'b0;
      end else if (state == SCAN) begin
        rd_idx <= rd_idx + 1'b1;
      end
      if (take_new) begin
        best_dist <= io_dist;
        best_idx  <= cmp_idx;
        have_best <= 1'b1;
      end
    end
  end

  assign io_dist_p1x = px_q;
  assign io_dist_p1y = py_q;
  assign io_dist_p2x = io_cent_x;
  assign io_dist_p2y = io_cent_y;
  assign io_out_idx  = best_idx;
  assign io_out_dist = best_dist;

endmodule

// File: tb/tb_nearest_centroid.sv
// tb/tb_nearest_centroid.sv - directed self-checking bench for nearest_centroid.
`timescale 1ns/1ps
module tb_nearest_centroid;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [63:0] io_px, io_py;
  logic [4:0]  io_num_centroids;
  logic        io_cent_en;
  logic [3:0]  io_cent_addr;
  logic [63:0] io_cent_x = '0, io_cent_y = '0;
  logic [63:0] io_dist_p1x, io_dist_p1y, io_dist_p2x, io_dist_p2y;
  logic [63:0] io_dist;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [3:0]  io_out_idx;
  logic [63:0] io_out_dist;

  logic [63:0] dist_tab [16];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nearest_centroid #(.MAX_K(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_px(io_px), .io_py(io_py), .io_num_centroids(io_num_centroids),
    .io_cent_en(io_cent_en), .io_cent_addr(io_cent_addr),
    .io_cent_x(io_cent_x), .io_cent_y(io_cent_y),
    .io_dist_p1x(io_dist_p1x), .io_dist_p1y(io_dist_p1y),
    .io_dist_p2x(io_dist_p2x), .io_dist_p2y(io_dist_p2y),
    .io_dist(io_dist),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_idx(io_out_idx), .io_out_dist(io_out_dist)
  );

  // Synchronous centroid memory: the address is encoded into x, and y is its complement.
  always @(posedge clk)
    if (io_cent_en) begin
      io_cent_x <= {60'h0123456789ABCDE, io_cent_addr};
      io_cent_y <= ~{60'h0123456789ABCDE, io_cent_addr};
    end

  // Distance operator stand-in: a zero distance is returned for any malformed p2 pair.
  assign io_dist = (io_dist_p2y == ~io_dist_p2x) ? dist_tab[io_dist_p2x[3:0]] : 64'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_tab(input real v [8]);
    for (int i = 0; i < 16; i++) dist_tab[i] = 64'h7FF0000000000000;
    for (int i = 0; i < 8; i++) dist_tab[i] = $realtobits(v[i]);
  endtask

  task automatic do_point(input string tag, input logic [4:0] k, input int eff_k,
                          input logic [3:0] exp_idx, input logic [63:0] exp_dist, input int hold);
    int lat;
    int en_cnt;
    logic [63:0] px_exp;
    px_exp = {$urandom, $urandom};
    io_px = px_exp;
    io_py = ~px_exp;
    io_num_centroids = k;
    io_in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(io_in_ready), 64'd1);
    step();
    io_in_valid = 1'b0;
    io_num_centroids = 5'd2;
    io_px = '0;
    io_py = '0;
    lat = 1;
    en_cnt = 0;
    while (!io_out_valid && lat < 40) begin
      if (io_cent_en) begin
        chk({tag, "_addr"}, 64'(io_cent_addr), 64'(en_cnt));
        en_cnt++;
      end
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(eff_k + 2));
    chk({tag, "_reads"}, 64'(en_cnt), 64'(eff_k));
    chk({tag, "_idx"}, 64'(io_out_idx), 64'(exp_idx));
    chk({tag, "_dist"}, io_out_dist, exp_dist);
    io_out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      io_in_valid = h[0];
      io_px = {$urandom, $urandom};
      step();
      chk({tag, "_hold_valid"}, 64'(io_out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(io_in_ready), 64'd0);
      chk({tag, "_hold_idx"}, 64'(io_out_idx), 64'(exp_idx));
      chk({tag, "_hold_dist"}, io_out_dist, exp_dist);
    end
    io_in_valid = 1'b0;
    chk({tag, "_p1x"}, io_dist_p1x, px_exp);
    chk({tag, "_p1y"}, io_dist_p1y, ~px_exp);
    io_out_ready = 1'b1;
    step();
    io_out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(io_out_valid), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(io_in_ready), 64'd1);
  endtask

  initial begin
    real tv [8];
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_out_ready = 1'b0;
    io_px = '0;
    io_py = '0;
    io_num_centroids = '0;
    for (int i = 0; i < 16; i++) dist_tab[i] = '0;
    step();
    step();
    chk("rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("rst_cent_en", 64'(io_cent_en), 64'd0);
    chk("rst_cent_addr", 64'(io_cent_addr), 64'd0);
    chk("rst_out_idx", 64'(io_out_idx), 64'd0);
    chk("rst_out_dist", io_out_dist, 64'd0);
    chk("rst_p1x", io_dist_p1x, 64'd0);
    reset = 1'b0;
    step();
    chk("idle_in_ready", 64'(io_in_ready), 64'd1);

    // Tie between indices 1 and 2 keeps index 1.
    tv = '{5.0, 1.0, 1.0, 9.0, 9.0, 9.0, 9.0, 9.0};
    set_tab(tv);
    do_point("t1", 5'd3, 3, 4'd1, 64'h3FF0000000000000, 0);

    for (int i = 0; i < 16; i++) dist_tab[i] = 64'h7FF0000000000000;
    do_point("t2_inf", 5'd1, 1, 4'd0, 64'h7FF0000000000000, 0);

    dist_tab[0] = 64'h7FF8000000000000;
    dist_tab[1] = 64'h4008000000000000;
    do_point("t2_nan", 5'd2, 2, 4'd1, 64'h4008000000000000, 0);

    dist_tab[0] = 64'h0;
    dist_tab[1] = 64'h3FF0000000000000;
    dist_tab[2] = 64'h8000000000000000;
    do_point("t5_negzero", 5'd3, 3, 4'd0, 64'h0, 0);
    do_point("t5_k0", 5'd0, 1, 4'd0, 64'h0, 0);

    for (int i = 0; i < 16; i++) dist_tab[i] = $realtobits(real'(16 - i));
    do_point("t3_k16", 5'd16, 16, 4'd15, 64'h3FF0000000000000, 0);
    do_point("t4_k20_bp", 5'd20, 16, 4'd15, 64'h3FF0000000000000, 10);

    // Abort a K=8 scan two cycles after accept.
    tv = '{9.0, 8.0, 7.0, 6.0, 5.0, 2.0, 3.0, 2.0};
    set_tab(tv);
    io_px = 64'h4000000000000000;
    io_py = 64'hBFF0000000000000;
    io_num_centroids = 5'd8;
    io_in_valid = 1'b1;
    step();
    io_in_valid = 1'b0;
    step();
    chk("t6_pre_en", 64'(io_cent_en), 64'd1);
    chk("t6_pre_idx", 64'(io_out_idx), 64'd15);
    reset = 1'b1;
    #1;
    chk("t6_rst_en", 64'(io_cent_en), 64'd0);
    chk("t6_rst_valid", 64'(io_out_valid), 64'd0);
    chk("t6_rst_idx", 64'(io_out_idx), 64'd0);
    chk("t6_rst_dist", io_out_dist, 64'd0);
    chk("t6_rst_p1x", io_dist_p1x, 64'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("t6_rel_in_ready", 64'(io_in_ready), 64'd1);
    chk("t6_rel_valid", 64'(io_out_valid), 64'd0);
    do_point("t6_after", 5'd8, 8, 4'd5, 64'h4000000000000000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nearest_centroid.md
Name: nearest_centroid

Overview:
- Assignment stage of the k-means datapath; sits directly downstream of the Euclidean-distance operator.
- Accepts one point, scans centroids 0..K-1 from an external synchronous centroid memory, and drives each (point, centroid) pair into the distance operator.
- Consumes the returned 64-bit double distance and tracks the running minimum.
- Emits the winning centroid index and its distance over a valid/ready handshake.

Parameters:
- MAX_K, 16, maximum centroid count supported by the scan counter.
- IDX_W, 4, centroid index width; equals clog2(MAX_K).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- io_in_valid  in  1  point available
- io_in_ready  out  1  block can accept a point
- io_px  in  64  point x (IEEE-754 double)
- io_py  in  64  point y (IEEE-754 double)
- io_num_centroids  in  IDX_W+1  runtime K, sampled at accept
- io_cent_en  out  1  centroid memory read enable
- io_cent_addr  out  IDX_W  centroid memory read address
- io_cent_x  in  64  centroid x; valid the cycle after io_cent_en
- io_cent_y  in  64  centroid y; same timing as io_cent_x
- io_dist_p1x  out  64  to distance operator: latched point x
- io_dist_p1y  out  64  to distance operator: latched point y
- io_dist_p2x  out  64  to distance operator: io_cent_x passed through combinationally
- io_dist_p2y  out  64  to distance operator: io_cent_y passed through combinationally
- io_dist  in  64  distance returned combinationally, same cycle as p2
- io_out_valid  out  1  result valid
- io_out_ready  in  1  consumer accepts result
- io_out_idx  out  IDX_W  index of nearest centroid
- io_out_dist  out  64  distance to nearest centroid (raw bits of the io_dist sample)

Behaviour:
- States: IDLE, SCAN, DRAIN, DONE.
- Reset (async, any state): state=IDLE; all registers, io_out_idx, io_out_dist, point latches and io_cent_addr cleared to 0; io_cent_en=0; io_out_valid=0.
- IDLE:
  - io_in_ready=1 in IDLE only.
  - On in_valid&in_ready: latch px/py and K, clear the have_best flag, set rd_idx=0, go to SCAN.
  - K clamps: K=0 is treated as 1; K>MAX_K is treated as MAX_K.
- SCAN:
  - io_cent_en=1, io_cent_addr=rd_idx; rd_idx increments each cycle.
  - The cycle rd_idx==K-1 is issued, go to DRAIN.
- Compare pipeline:
  - A 1-bit cmp_valid register, with cmp_idx, follows each issued read by one cycle.
  - When cmp_valid: if !have_best, or key(io_dist) < key(best_dist), load best_dist=io_dist and best_idx=cmp_idx, then set have_best.
  - key(d) = {1'b0, d[62:0]}: unsigned compare with the sign masked, so -0.0 equals +0.0.
  - Strict less-than: on ties the lower index is kept.
  - NaN/inf sort above all finite values; the first sample always loads.
- DRAIN: io_cent_en=0; performs the final compare; go to DONE.
- DONE:
  - io_out_valid=1; io_out_idx=best_idx; io_out_dist=best_dist.
  - Outputs are held stable until io_out_ready; on handshake go to IDLE.
  - io_in_ready stays 0 until the cycle after that handshake (no overlap).
- Latency: accept edge at cycle t → io_out_valid high in cycle t+K+2.
  - K=1 gives 3 cycles; K=16 gives 18 cycles.
- io_dist_p1x/p1y hold the latched point from accept until the next accept.
- io_in_valid is ignored outside IDLE. io_px/py/io_num_centroids changes after accept have no effect.
- Reset during SCAN/DRAIN/DONE aborts the point; no io_out_valid is produced for it.

Test Plan:
1. Point (0,0), K=3, centroids (3,4),(1,0),(0,1); dist seq 0x4014000000000000, 0x3FF0000000000000, 0x3FF0000000000000 → idx=1 (tie keeps lower), dist=0x3FF0000000000000; out_valid at t+5; cent_addr sequence 0,1,2 in cycles t+1..t+3.
2. K=1, any centroid, dist 0x7FF0000000000000 (+inf) → idx=0, dist=+inf, out_valid at t+3.
3. K=16, distances descending 16.0..1.0 → idx=15, dist=0x3FF0000000000000, latency 18; then K=20 → clamps to 16, identical timing.
4. Backpressure: io_out_ready=0 for 10 cycles in DONE → outputs stable, io_in_ready=0, io_in_valid pulses ignored; then ready=1 → IDLE next cycle, next point accepted.
5. Dist 0x8000000000000000 (-0.0) at idx 2 vs 0x0 at idx 0 → keys equal, idx=0 retained; K=0 → behaves as K=1.
6. Assert reset at cycle t+2 of a K=8 scan → io_cent_en, io_out_valid, io_out_idx and io_out_dist read 0 immediately (async); after release, io_in_ready=1 and a new point completes normally with correct result.
